// File: rtl/bus_timer_pkg.sv
// Shared constants and types for the memory-mapped bus timer.
// Holds the register map, CTRL/STATUS bit positions and the CTRL pack/unpack helpers.
package bus_timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_F020;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PRE_W  = 8;

    // Word offsets within the 16-byte window (adr[3:2])
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_AUTO_BIT = 1;
    localparam int unsigned CTRL_IE_BIT   = 2;
    localparam int unsigned CTRL_PRE_LSB  = 8;
    localparam int unsigned CTRL_PRE_MSB  = 15;

    localparam int unsigned STATUS_EXP_BIT = 0;
    localparam int unsigned STATUS_OVR_BIT = 1;

    typedef struct packed {
        logic [PRE_W-1:0] pre;
        logic             ie;
        logic             auto_rl;
        logic             en;
    } ctrl_t;

    function automatic ctrl_t ctrl_unpack(input logic [DATA_W-1:0] w);
        ctrl_t c;
        c.en      = w[CTRL_EN_BIT];
        c.auto_rl = w[CTRL_AUTO_BIT];
        c.ie      = w[CTRL_IE_BIT];
        c.pre     = w[CTRL_PRE_MSB:CTRL_PRE_LSB];
        return c;
    endfunction

    // Unimplemented CTRL bits read back as zero
    function automatic logic [DATA_W-1:0] ctrl_pack(input ctrl_t c);
        logic [DATA_W-1:0] w;
        w                             = '0;
        w[CTRL_EN_BIT]                = c.en;
        w[CTRL_AUTO_BIT]              = c.auto_rl;
        w[CTRL_IE_BIT]                = c.ie;
        w[CTRL_PRE_MSB:CTRL_PRE_LSB]  = c.pre;
        return w;
    endfunction

endpackage

// File: rtl/bus_timer_if.sv
// Bus-side signal bundle for the timer register window.
interface bus_timer_if;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic        irq;

    modport master (output adr, output wd, output we, input rd, input irq);
    modport slave  (input adr, input wd, input we, output rd, output irq);
endinterface

// File: rtl/bus_timer_prescaler.sv
// 8-bit prescaler: counts 0..pre while enabled, tick when the count equals pre.
module timer_prescaler
    import bus_timer_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] pre,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q;

    assign tick = en & (cnt_q == pre);

    // Held at zero while disabled; a CTRL write restarts the period
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (!en || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRE_W'(1);
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and W1C status.
// Four word registers: CTRL, LOAD, COUNT (read-only), STATUS.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] adr_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic              we_i,
    output logic [DATA_W-1:0] rd_o,
    output logic              irq_o
);

    logic             hit;
    logic [1:0]       off;
    logic             wr_ctrl;
    logic             wr_load;
    logic             wr_status;
    logic             unused_adr;

    ctrl_t             ctrl_q;
    logic [DATA_W-1:0] load_q;
    logic [DATA_W-1:0] count_q;
    logic              exp_q;
    logic              ovr_q;

    logic [DATA_W-1:0] count_d;
    logic              exp_d;
    logic              ovr_d;
    logic              expire;
    logic              tick;

    assign hit        = (adr_i[31:4] == BASE_ADDR[31:4]);
    assign off        = adr_i[3:2];
    assign unused_adr = ^adr_i[1:0];

    assign wr_ctrl   = we_i & hit & (off == OFF_CTRL);
    assign wr_load   = we_i & hit & (off == OFF_LOAD);
    assign wr_status = we_i & hit & (off == OFF_STATUS);

    timer_prescaler u_prescaler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en      (ctrl_q.en),
        .clr     (wr_ctrl),
        .pre     (ctrl_q.pre),
        .tick    (tick)
    );

    // Count update: a LOAD write overrides any tick in the same cycle
    always_comb begin
        count_d = count_q;
        expire  = 1'b0;
        if (wr_load) begin
            count_d = wd_i;
        end else if (tick) begin
            if (count_q > DATA_W'(1)) begin
                count_d = count_q - DATA_W'(1);
            end else if (count_q == DATA_W'(1)) begin
                expire  = 1'b1;
                count_d = ctrl_q.auto_rl ? load_q : '0;
            end
        end
    end

    // Status flags: hardware set takes priority over a same-cycle W1C
    always_comb begin
        exp_d = expire | (exp_q & ~(wr_status & wd_i[STATUS_EXP_BIT]));
        ovr_d = (expire & exp_q) | (ovr_q & ~(wr_status & wd_i[STATUS_OVR_BIT]));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= ctrl_unpack(wd_i);
            end
            if (wr_load) begin
                load_q <= wd_i;
            end
            count_q <= count_d;
            exp_q   <= exp_d;
            ovr_q   <= ovr_d;
        end
    end

    // Zero-latency read mux, sourced from registered state only
    always_comb begin
        rd_o = '0;
        if (hit) begin
            case (off)
                OFF_CTRL:   rd_o = ctrl_pack(ctrl_q);
                OFF_LOAD:   rd_o = load_q;
                OFF_COUNT:  rd_o = count_q;
                OFF_STATUS: rd_o = {30'd0, ovr_q, exp_q};
                default:    rd_o = '0;
            endcase
        end
    end

    assign irq_o = exp_q & ctrl_q.ie;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus randomized bus traffic
// compared every cycle against a behavioural register-level model.
module tb_bus_timer;
    import bus_timer_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_F020;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bus_timer_if bif ();

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .adr_i   (bif.adr),
        .wd_i    (bif.wd),
        .we_i    (bif.we),
        .rd_o    (bif.rd),
        .irq_o   (bif.irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural state as software sees it, plus the prescaler phase
    typedef struct packed {
        logic        en;
        logic        auto_rl;
        logic        ie;
        logic [7:0]  pre;
        logic [7:0]  psc;
        logic [31:0] load;
        logic [31:0] count;
        logic        exp_f;
        logic        ovr_f;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_step(input mstate_t s, input logic we,
                                           input logic [31:0] a, input logic [31:0] d);
        mstate_t n;
        logic    hit;
        logic    tick;
        logic    expire;
        logic    w_ctrl, w_load, w_stat;
        n      = s;
        hit    = we && ((a >> 4) == (BASE >> 4));
        w_ctrl = hit && (a[3:2] == 2'd0);
        w_load = hit && (a[3:2] == 2'd1);
        w_stat = hit && (a[3:2] == 2'd3);
        tick   = s.en && (s.psc == s.pre);
        expire = 1'b0;
        if (w_load) begin
            n.count = d;
            n.load  = d;
        end else if (tick && s.count != 0) begin
            if (s.count == 1) begin
                expire  = 1'b1;
                n.count = s.auto_rl ? s.load : 32'd0;
            end else begin
                n.count = s.count - 1;
            end
        end
        if (w_ctrl || !s.en || tick) n.psc = 8'd0;
        else                         n.psc = s.psc + 8'd1;
        if (w_ctrl) begin
            n.en      = d[0];
            n.auto_rl = d[1];
            n.ie      = d[2];
            n.pre     = d[15:8];
        end
        n.exp_f = expire || (s.exp_f && !(w_stat && d[0]));
        n.ovr_f = (expire && s.exp_f) || (s.ovr_f && !(w_stat && d[1]));
        return n;
    endfunction

    function automatic logic [31:0] model_rd(input mstate_t s, input logic [31:0] a);
        if ((a >> 4) != (BASE >> 4)) return 32'd0;
        case (a[3:2])
            2'd0:    return {16'd0, s.pre, 5'd0, s.ie, s.auto_rl, s.en};
            2'd1:    return s.load;
            2'd2:    return s.count;
            default: return {30'd0, s.ovr_f, s.exp_f};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, bif.we, bif.adr, bif.wd);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        chk("rd_model", bif.rd, model_rd(m, bif.adr));
        chk("irq_model", {31'd0, bif.irq}, {31'd0, m.exp_f & m.ie});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        bif.adr = BASE + {28'd0, off, 2'b00};
        bif.wd  = d;
        bif.we  = 1'b1;
        step(1);
        bif.we  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] off, input logic [31:0] expv);
        bif.adr = BASE + {28'd0, off, 2'b00};
        #1;
        chk(name, bif.rd, expv);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        logic [1:0]  off;
        logic [31:0] w;
        int          r;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bif.adr  = '0;
        bif.wd   = '0;
        bif.we   = 1'b0;
        #23 rst_n = 1'b1;
        step(1);

        // Reset values and miss decode
        rd_chk("rst_ctrl",   OFF_CTRL,   32'd0);
        rd_chk("rst_load",   OFF_LOAD,   32'd0);
        rd_chk("rst_count",  OFF_COUNT,  32'd0);
        rd_chk("rst_status", OFF_STATUS, 32'd0);
        chk("rst_irq", {31'd0, bif.irq}, 32'd0);
        bif.adr = 32'hFFFF_F030;
        #1 chk("miss_rd", bif.rd, 32'd0);

        // One-shot with interrupt
        wr(OFF_LOAD, 32'd3);
        wr(OFF_CTRL, 32'h0000_0005);
        rd_chk("os_ctrl", OFF_CTRL, 32'h0000_0005);
        rd_chk("os_c3", OFF_COUNT, 32'd3);
        step(1); rd_chk("os_c2", OFF_COUNT, 32'd2);
        step(1); rd_chk("os_c1", OFF_COUNT, 32'd1);
        step(1); rd_chk("os_c0", OFF_COUNT, 32'd0);
        rd_chk("os_exp", OFF_STATUS, 32'd1);
        chk("os_irq", {31'd0, bif.irq}, 32'd1);
        step(2); rd_chk("os_hold", OFF_COUNT, 32'd0);
        wr(OFF_COUNT, 32'h55);
        rd_chk("count_ro", OFF_COUNT, 32'd0);

        // Prescale 4 with auto-reload, then overrun
        do_reset();
        wr(OFF_LOAD, 32'd2);
        wr(OFF_CTRL, 32'h0000_0303);
        rd_chk("ps_ctrl", OFF_CTRL, 32'h0000_0303);
        rd_chk("ps_c2a", OFF_COUNT, 32'd2);
        step(3); rd_chk("ps_c2b", OFF_COUNT, 32'd2);
        step(1); rd_chk("ps_c1a", OFF_COUNT, 32'd1);
        step(4); rd_chk("ps_c2c", OFF_COUNT, 32'd2);
        rd_chk("ps_exp", OFF_STATUS, 32'd1);
        step(4); rd_chk("ps_c1b", OFF_COUNT, 32'd1);
        step(4); rd_chk("ps_c2d", OFF_COUNT, 32'd2);
        rd_chk("ps_ovr", OFF_STATUS, 32'd3);
        chk("ps_noirq", {31'd0, bif.irq}, 32'd0);

        // W1C colliding with expiry
        do_reset();
        wr(OFF_LOAD, 32'd3);
        wr(OFF_CTRL, 32'h0000_0005);
        step(2);
        rd_chk("w1c_pre", OFF_COUNT, 32'd1);
        wr(OFF_STATUS, 32'd1);
        rd_chk("w1c_setwins", OFF_STATUS, 32'd1);
        chk("w1c_irq1", {31'd0, bif.irq}, 32'd1);
        wr(OFF_STATUS, 32'd3);
        rd_chk("w1c_clear", OFF_STATUS, 32'd0);
        chk("w1c_irq0", {31'd0, bif.irq}, 32'd0);

        // LOAD write coinciding with a tick
        do_reset();
        wr(OFF_LOAD, 32'd5);
        wr(OFF_CTRL, 32'h0000_0001);
        rd_chk("ld_c5", OFF_COUNT, 32'd5);
        wr(OFF_LOAD, 32'd10);
        rd_chk("ld_c10", OFF_COUNT, 32'd10);
        step(1); rd_chk("ld_c9", OFF_COUNT, 32'd9);

        // Asynchronous reset mid-count
        do_reset();
        wr(OFF_LOAD, 32'd9);
        wr(OFF_CTRL, 32'h0000_0005);
        step(2);
        rd_chk("ar_c7", OFF_COUNT, 32'd7);
        rst_n = 1'b0;
        rd_chk("ar_count", OFF_COUNT, 32'd0);
        rd_chk("ar_ctrl", OFF_CTRL, 32'd0);
        chk("ar_irq", {31'd0, bif.irq}, 32'd0);
        #2 rst_n = 1'b1;
        step(1);
        step(3);
        rd_chk("ar_idle", OFF_COUNT, 32'd0);
        rd_chk("ar_ctrl2", OFF_CTRL, 32'd0);

        // Randomized traffic against the model
        do_reset();
        repeat (3000) begin
            r   = int'($urandom_range(0, 99));
            off = 2'($urandom_range(0, 3));
            case (off)
                OFF_CTRL: begin
                    w        = $urandom;
                    w[15:8]  = 8'($urandom_range(0, 3));
                    w[0]     = ($urandom_range(0, 4) != 0);
                end
                OFF_LOAD:  w = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
                default:   w = $urandom;
            endcase
            bif.adr = (r < 85) ? (BASE + {28'd0, off, 2'b00}) : $urandom;
            bif.wd  = w;
            bif.we  = ($urandom_range(0, 3) == 0);
            step(1);
        end
        bif.we = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'hFFFF_F020, giving the 16-byte-aligned base of the register window.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock, the CPU clock clk_g.
REQ-003 The block SHALL have port rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port adr_i, input, 32 bits: byte address from the bus IO side.
REQ-005 The block SHALL have port wd_i, input, 32 bits: write data.
REQ-006 The block SHALL have port we_i, input, 1 bit: write enable, sampled on the rising edge of clk_i.
REQ-007 The block SHALL have port rd_o, output, 32 bits: combinational read data.
REQ-008 The block SHALL have port irq_o, output, 1 bit: level interrupt request.

Function
REQ-009 The block SHALL decode a hit when adr_i[31:4] == BASE_ADDR[31:4]; offset = adr_i[3:2].
REQ-010 The block SHALL define CTRL at offset 0 (R/W): bit0 EN, bit1 AUTO, bit2 IE, bits[15:8] PRE; all other bits SHALL read 0.
REQ-011 The block SHALL define LOAD at offset 1 (R/W, 32 bits).
REQ-012 The block SHALL define COUNT at offset 2 (read-only); writes to it SHALL be ignored.
REQ-013 The block SHALL define STATUS at offset 3: bit0 EXP, bit1 OVR, write-1-to-clear per bit.
REQ-014 rd_o SHALL be the addressed register when there is a hit, else 32'h0; there SHALL be zero cycles of read latency.
REQ-015 Writes SHALL take effect at the clock edge where we_i=1 and there is a hit; byte lanes are not supported (full-word writes only).
REQ-016 The 8-bit prescaler SHALL count 0..PRE while EN=1 and assert a one-cycle tick when it equals PRE, then wrap to 0; PRE=0 SHALL give a tick every cycle.
REQ-017 With EN=0, the prescaler SHALL be held at 0 and COUNT SHALL be frozen.
REQ-018 Any CTRL write SHALL clear the prescaler to 0.
REQ-019 A LOAD write SHALL also set COUNT to wd_i in the same edge; if a tick coincides, the write SHALL win and no decrement occurs.
REQ-020 On a tick with COUNT>1, COUNT SHALL decrement by 1.
REQ-021 On a tick with COUNT==1 (expiry), the block SHALL set EXP, and COUNT SHALL become LOAD if AUTO=1, else 0.
REQ-022 On a tick with COUNT==0, there SHALL be no change and no expiry; this covers the one-shot-done state and the LOAD=0 case.
REQ-023 Expiry while EXP is already 1 SHALL set OVR.
REQ-024 A set and a W1C on the same bit in the same cycle SHALL resolve as set wins.
REQ-025 irq_o SHALL equal EXP & IE, decoded combinationally from registered state only.
REQ-026 All counters SHALL use modulo arithmetic with no saturation; COUNT never wraps below 0 per REQ-022.

Reset
REQ-027 On rst_n_i=0, asynchronously, the block SHALL set CTRL=0, LOAD=0, COUNT=0, prescaler=0, EXP=0, OVR=0; irq_o SHALL be 0 and rd_o SHALL depend on adr_i only.
REQ-028 A reset mid-count SHALL discard all state; after release, the timer SHALL remain idle until software writes CTRL.EN=1.

Structure
REQ-029 A shared package or include (param.v) SHALL hold the default base address, register offsets (CTRL/LOAD/COUNT/STATUS), CTRL and STATUS bit positions, and the PRE field range.
REQ-030 The block SHALL contain one sub-module, timer_prescaler (inputs: en, clr, pre[7:0]; output: tick), with all register logic in bus_timer.
REQ-031 The block SHALL have no latches and no combinational path from wd_i to rd_o.

Verification
REQ-032 Reset value check: release reset, read offsets 0..3 -> all 0, irq_o=0; read adr 32'hFFFF_F030 -> rd_o=0.
REQ-033 One-shot: LOAD=3, CTRL=32'h0000_0005 (EN, IE, PRE=0) -> COUNT reads 2, 1, 0 on successive cycles; EXP=1 and irq_o=1 on the edge where COUNT reaches 0; COUNT then holds at 0.
REQ-034 Prescale and auto-reload: LOAD=2, CTRL=32'h0000_0303 (PRE=3, AUTO, EN) -> a decrement every 4 cycles; COUNT sequence 2,1,2,1...; EXP set at the first expiry; OVR set at the second expiry without a clear.
REQ-035 W1C collision: write STATUS=1 on the exact cycle of an expiry -> EXP stays 1; a later write of STATUS=3 -> EXP=0, OVR=0, irq_o=0.
REQ-036 LOAD/tick collision: COUNT=5, PRE=0, write LOAD=10 on a tick cycle -> COUNT=10 the next cycle, not 9 and not 4.
REQ-037 Reset mid-operation: assert rst_n_i=0 asynchronously between edges while COUNT=7 -> COUNT=0 and CTRL=0 immediately; irq_o=0.
